crc5_check: RTL and testbench

//  Receive-side USB CRC5 checker: the counterpart to the token/SOF CRC5 generator.

---
 rtl/usb_crc_pkg.sv | 17 +
 rtl/crc5_check_if.sv | 39 +++
 rtl/crc5_lfsr.sv | 23 ++
 rtl/crc5_check.sv | 150 +++++++++++++++
 tb/tb_crc5_check.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/usb_crc_pkg.sv
// rtl/usb_crc_pkg.sv - USB CRC5 constants, checker state type and LFSR step
package usb_crc_pkg;

  localparam logic [4:0] CRC5_POLY     = 5'b00101;
  localparam logic [4:0] CRC5_PRESET   = 5'b11111;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DONE} crc5_state_t;

  // One serial step of x^5+x^2+1, MSB-out feedback
  function automatic logic [4:0] crc5_step(input logic [4:0] q, input logic b);
    logic fb;
    fb = q[4] ^ b;
    return {q[3:0], 1'b0} ^ ({5{fb}} & CRC5_POLY);
  endfunction

endpackage

// File: rtl/crc5_check_if.sv
// rtl/crc5_check_if.sv - bit stream and status bundle for crc5_check; err_cnt exists with CRC5_ERR_CNT_EN
interface crc5_check_if #(
  parameter int DATA_BITS = 11
`ifdef CRC5_ERR_CNT_EN
  , parameter int ERR_CNT_W = 8
`endif
);

  logic                 crc5_start;
  logic                 bit_valid;
  logic                 s_in;
  logic                 abort;
  logic                 crc5_rec;
  logic [DATA_BITS-1:0] payload;
  logic                 crc5_busy;
  logic                 crc5_done;
  logic                 crc5_ok;
  logic                 crc5_err;
`ifdef CRC5_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
`endif

  modport master (
    output crc5_start, bit_valid, s_in, abort, crc5_rec,
    input  payload, crc5_busy, crc5_done, crc5_ok, crc5_err
`ifdef CRC5_ERR_CNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  crc5_start, bit_valid, s_in, abort, crc5_rec,
    output payload, crc5_busy, crc5_done, crc5_ok, crc5_err
`ifdef CRC5_ERR_CNT_EN
    , output err_cnt
`endif
  );

endinterface

// File: rtl/crc5_lfsr.sv
// rtl/crc5_lfsr.sv - USB CRC5 shift register with synchronous preset and shift enable
module crc5_lfsr
  import usb_crc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       preset,
  input  logic       shift,
  input  logic       bit_in,
  output logic [4:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= CRC5_PRESET;
    end else if (preset) begin
      q <= CRC5_PRESET;
    end else if (shift) begin
      q <= crc5_step(q, bit_in);
    end
  end

endmodule

// File: rtl/crc5_check.sv
// rtl/crc5_check.sv - USB CRC5 receive checker; CRC5_ERR_CNT_EN adds a saturating error counter
module crc5_check
  import usb_crc_pkg::*;
#(
  parameter int DATA_BITS = 11
`ifdef CRC5_ERR_CNT_EN
  , parameter int ERR_CNT_W = 8
`endif
) (
  input logic         clk,
  input logic         rst,
  crc5_check_if.slave bus
);

  localparam int            CW        = $clog2(DATA_BITS > 5 ? DATA_BITS : 5);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_CRC  = CW'(4);

  crc5_state_t          state, state_n;
  logic [CW-1:0]        count;
  logic [DATA_BITS-1:0] payload_r;
  logic [4:0]           q;
  logic                 preset, shift, capture, cnt_clr, cnt_inc, done_entry;
  logic                 match, ok_r, err_r;

  crc5_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .preset (preset),
    .shift  (shift),
    .bit_in (bus.s_in),
    .q      (q)
  );

  // Judged on the value the LFSR takes with the last CRC bit, so status lands with done
  assign match = (crc5_step(q, bus.s_in) == CRC5_RESIDUAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    preset     = 1'b0;
    shift      = 1'b0;
    capture    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    done_entry = 1'b0;
    case (state)
      IDLE: begin
        if (bus.crc5_start) begin
          state_n = PAYLOAD;
          preset  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      PAYLOAD: begin
        if (bus.crc5_start) begin
          preset  = 1'b1;
          cnt_clr = 1'b1;
        end else if (bus.abort) begin
          state_n = IDLE;
        end else if (bus.bit_valid) begin
          shift   = 1'b1;
          capture = 1'b1;
          if (count == LAST_DATA) begin
            state_n = CHECK;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      CHECK: begin
        if (bus.crc5_start) begin
          state_n = PAYLOAD;
          preset  = 1'b1;
          cnt_clr = 1'b1;
        end else if (bus.abort) begin
          state_n = IDLE;
        end else if (bus.bit_valid) begin
          shift = 1'b1;
          if (count == LAST_CRC) begin
            state_n    = DONE;
            cnt_clr    = 1'b1;
            done_entry = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DONE: begin
        // A start is only honoured together with the acknowledge
        if (bus.crc5_rec) begin
          if (bus.crc5_start) begin
            state_n = PAYLOAD;
            preset  = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      payload_r <= '0;
      ok_r      <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      if (cnt_clr)      count <= '0;
      else if (cnt_inc) count <= count + CW'(1);
      if (capture) payload_r[count] <= bus.s_in;
      if (done_entry) begin
        ok_r  <= match;
        err_r <= ~match;
      end else if (state_n != DONE) begin
        ok_r  <= 1'b0;
        err_r <= 1'b0;
      end
    end
  end

`ifdef CRC5_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= '0;
    end else if (done_entry && !match && (err_cnt_r != '1)) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
    end
  end

  assign bus.err_cnt = err_cnt_r;
`endif

  assign bus.payload   = payload_r;
  assign bus.crc5_busy = (state == PAYLOAD) || (state == CHECK);
  assign bus.crc5_done = (state == DONE);
  assign bus.crc5_ok   = ok_r;
  assign bus.crc5_err  = err_r;

endmodule

// File: tb/tb_crc5_check.sv
// tb/tb_crc5_check.sv - scoreboard bench for crc5_check; err_cnt checks with CRC5_ERR_CNT_EN
module tb_crc5_check;

  localparam int DB = 11;

  typedef struct {
    logic          ok;
    logic [DB-1:0] pl;
    logic [7:0]    cnt;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  logic [7:0]    exp_cnt = 8'h00;
  logic [DB-1:0] last_pl = '0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc5_check_if #(.DATA_BITS(DB)) bus ();

  crc5_check #(.DATA_BITS(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reflected-form generator (poly 0x14 shifting right), independent of the DUT's LFSR layout
  function automatic logic [4:0] crc5_gen(input logic [DB-1:0] d);
    logic [4:0] r;
    r = 5'h1F;
    for (int i = 0; i < DB; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
    return ~r;
  endfunction

  task automatic send_stream(input logic [DB-1:0] pl, input logic [4:0] crc, input bit gaps,
                             input bit do_start, input bit exp_ok);
    logic [DB+4:0] s;
    exp_t e;
    s = {crc, pl};
    if (do_start) begin
      @(negedge clk); bus.crc5_start = 1'b1; bus.bit_valid = 1'b0;
    end
    for (int i = 0; i < DB + 5; i++) begin
      if (gaps) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk); bus.crc5_start = 1'b0; bus.bit_valid = 1'b0; bus.s_in = ~s[i];
        end
      end
      @(negedge clk); bus.crc5_start = 1'b0; bus.bit_valid = 1'b1; bus.s_in = s[i];
      if (i == DB + 4) begin
        if (!exp_ok && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        e.ok = exp_ok; e.pl = pl; e.cnt = exp_cnt; e.cyc = cyc + 1;
        sb_q.push_back(e);
        last_pl = pl;
      end
    end
    @(negedge clk); bus.bit_valid = 1'b0; bus.s_in = 1'b0;
  endtask

  task automatic send_partial(input logic [DB-1:0] pl, input int n);
    logic [DB+4:0] s;
    s = {5'b0, pl};
    @(negedge clk); bus.crc5_start = 1'b1; bus.bit_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bus.crc5_start = 1'b0; bus.bit_valid = 1'b1; bus.s_in = s[i];
    end
    @(negedge clk); bus.bit_valid = 1'b0; bus.s_in = 1'b0;
  endtask

  task automatic ack();
    int n;
    n = 0;
    while (bus.crc5_done !== 1'b1 && n < 8) begin
      @(negedge clk); n++;
    end
    check("done_seen", bus.crc5_done, 1);
    bus.crc5_rec = 1'b1;
    @(negedge clk); bus.crc5_rec = 1'b0;
    check("idle_after_rec", {bus.crc5_done, bus.crc5_busy}, 0);
  endtask

  // Monitor: every rising crc5_done consumes one scoreboard entry
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.crc5_done === 1'b1 && !prev) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_done: crc5_done rose with nothing expected at cycle %0d", cyc);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("crc5_ok", bus.crc5_ok, e.ok);
          check("crc5_err", bus.crc5_err, !e.ok);
          check("payload", bus.payload, e.pl);
`ifdef CRC5_ERR_CNT_EN
          check("err_cnt", bus.err_cnt, e.cnt);
`endif
        end
      end
      prev = (bus.crc5_done === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [DB-1:0] p;
    bus.crc5_start = 1'b0; bus.bit_valid = 1'b0; bus.s_in = 1'b0;
    bus.abort = 1'b0; bus.crc5_rec = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("reset_status", {bus.crc5_busy, bus.crc5_done, bus.crc5_ok, bus.crc5_err}, 0);
    check("reset_payload", bus.payload, 0);
`ifdef CRC5_ERR_CNT_EN
    check("reset_err_cnt", bus.err_cnt, 0);
`endif
    @(negedge clk); rst = 1'b0;

    // Zero token, good CRC (wire 0,1,0,0,0), then bit 2 flipped, then with stuff gaps
    send_stream('0, 5'b00010, 1'b0, 1'b1, 1'b1); ack();
    send_stream('0, 5'b00110, 1'b0, 1'b1, 1'b0); ack();
    send_stream('0, 5'b00010, 1'b1, 1'b1, 1'b1); ack();

    foreach (p[i]) p[i] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p = (k == 0) ? 11'h7FF : (k == 1) ? 11'h555 : 11'h3A6;
      send_stream(p, crc5_gen(p), 1'b0, 1'b1, 1'b1); ack();
      send_stream(p, crc5_gen(p) ^ 5'b10000, 1'b0, 1'b1, 1'b0); ack();
    end

    // Restart mid-payload
    send_partial(11'h7FF, 4);
    check("busy_partial", bus.crc5_busy, 1);
    send_stream(11'h123, crc5_gen(11'h123), 1'b0, 1'b1, 1'b1); ack();

    // Abort after payload bit 6
    send_partial(11'h2AA, 7);
    bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    check("abort_busy", {bus.crc5_busy, bus.crc5_done}, 0);
    check("abort_payload", bus.payload, {last_pl[DB-1:7], 7'h2A});
    repeat (4) @(negedge clk);
    check("abort_no_done", bus.crc5_done, 0);
    send_stream('0, 5'b00010, 1'b0, 1'b1, 1'b1); ack();

    // Done held without ack; start and abort ignored meanwhile
    send_stream(11'h2C3, crc5_gen(11'h2C3), 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bus.crc5_start = (i == 3);
      bus.abort = (i == 6);
      @(negedge clk);
      check("hold_done", {bus.crc5_done, bus.crc5_ok, bus.crc5_err}, 3'b110);
      check("hold_payload", bus.payload, 11'h2C3);
    end
    bus.abort = 1'b0; bus.crc5_start = 1'b1; bus.crc5_rec = 1'b1;
    @(negedge clk); bus.crc5_start = 1'b0; bus.crc5_rec = 1'b0;
    check("rec_start_busy", {bus.crc5_busy, bus.crc5_done}, 2'b10);
    send_stream(11'h4E1, crc5_gen(11'h4E1), 1'b0, 1'b0, 1'b1); ack();

    // Asynchronous reset while in CHECK
    send_partial('0, DB + 2);
    check("in_check_busy", bus.crc5_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_status", {bus.crc5_busy, bus.crc5_done, bus.crc5_ok, bus.crc5_err}, 0);
    check("async_rst_payload", bus.payload, 0);
`ifdef CRC5_ERR_CNT_EN
    check("async_rst_err_cnt", bus.err_cnt, 0);
`endif
    exp_cnt = 8'h00;
    @(negedge clk); rst = 1'b0;
    send_stream('0, 5'b00010, 1'b0, 1'b1, 1'b1); ack();

    for (int k = 0; k < 256; k++) begin
      send_stream('0, 5'b00110, 1'b0, 1'b1, 1'b0); ack();
    end
`ifdef CRC5_ERR_CNT_EN
    check("err_cnt_saturated", bus.err_cnt, 8'hFF);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
